rgb_dosing_sequencer: RTL and testbench
=======================================

# rgb_dosing_sequencer

- Sequences the three dye-dispensing motors (R, G, B) of the mixer.
- Starts on an operator `enter` press once all three cycle counts are loaded.
- Runs each motor in turn for its programmed number of time-base ticks, then reports completion.
- Sits between the RGB count memory / keypad path and the motor outputs, replacing the separate timer + FSM pair with one block.

## Interface
Parameters:
- `CNT_W`, 5: width of each cycle count and of the internal tick counter.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `tick`  in  1  one-`clk` pulse per dosing time unit (400 ms time base); ignored when not running.
- `enter`  in  1  start button level, already synchronized and debounced to `clk`; block edge-detects internally.
- `rgb_full`  in  1  high when all three counts are valid.
- `ciclos_r`  in  CNT_W  R run length in ticks.
- `ciclos_g`  in  CNT_W  G run length in ticks.
- `ciclos_b`  in  CNT_W  B run length in ticks.
- `motores`  out  3  motor enables, [2]=R, [1]=G, [0]=B; at most one bit high.
- `flags`  out  3  per-channel completion, same bit order.
- `busy`  out  1  high while a sequence is running.
- `done`  out  1  one-cycle pulse at end of a sequence.

## Operation
- States: IDLE, RUN_R, RUN_G, RUN_B, DONE.
- Start event: rising edge of `enter` (`enter`=1, previous-cycle `enter`=0) while in IDLE with `rgb_full`=1.
  - Edge with `rgb_full`=0 is discarded; it does not arm a later start.
- On start:
  - latch `ciclos_r/g/b` into internal registers;
  - clear `flags` and the tick counter;
  - go to the first channel in R→G→B order whose latched count is nonzero.
  - Inputs changing after the latch have no effect on the running sequence.
- Zero-count channel: skipped; its flag is set on the same edge it is skipped.
  - All three zero: IDLE→DONE directly, all flags set.
- RUN_x:
  - `motores` is one-hot for channel x; counter increments on each `tick`.
  - On the `tick` where counter == count−1:
    - set `flags[x]`;
    - clear counter;
    - move to the next nonzero channel, or DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE. `flags` hold until the next start or reset.
- `busy` = 1 in RUN_R/RUN_G/RUN_B, 0 in IDLE/DONE.
- `enter` edges while busy are ignored (unless SEQ_ABORT_EN; see Configuration).
- `tick` in IDLE/DONE is ignored; counter stays 0.

## Timing
- Reset values: state IDLE, `motores`=000, `flags`=000, `busy`=0, `done`=0, counter 0, latched counts 0.
- Asynchronous reset mid-run turns motors off immediately, without waiting for `clk`.
- All outputs are registered; no combinational input→output path.
- Start latency:
  - start edge seen in cycle n;
  - `motores` and `busy` valid from cycle n+1.
- Channel handoff: on the completing `tick` edge, the old motor bit drops and the next motor bit rises together. No gap, no overlap.
- Run length:
  - channel with count N is on for exactly N `tick` pulses;
  - the first interval may be partial, since the start is not aligned to `tick`.
- After the last channel completes (edge m): `done`=1 and `busy`=0 in cycle m; IDLE in cycle m+1.
- New start is accepted no earlier than cycle m+1.
- Counter width CNT_W; count 2^CNT_W−1 = 31 must run the full 31 ticks without wrap.

## Configuration
- `SEQ_ABORT_EN` defined:
  - `enter` rising edge while busy aborts the sequence;
  - `motores`→000, `busy`→0, state→IDLE on the next edge;
  - no `done` pulse; `flags` keep the channels already completed.
  - An abort edge and a completing `tick` in the same cycle: abort wins.
- `SEQ_ABORT_EN` undefined: `enter` ignored while busy; the sequence always runs to completion.

## Test plan
- Reset, then R=3, G=2, B=1, `rgb_full`=1, press `enter` → `motores` 100 for 3 ticks, 010 for 2, 001 for 1; `flags` 100→110→111; one `done` pulse; never two motor bits high.
- R=0, G=4, B=0 → only 010 for 4 ticks; `flags`=101 from start cycle+1, 111 at the end.
- All counts 0 → no motor on; `done` one cycle after the start edge; `flags`=111.
- `rgb_full`=0 at `enter` edge, then raised → stays IDLE, `motores`=000 until a fresh `enter` edge.
- Change `ciclos_r` from 2 to 9 mid-RUN_R → R still runs 2 ticks. Assert `reset` mid-RUN_G → `motores`=000 asynchronously, `flags`=000.
- With SEQ_ABORT_EN: `enter` edge during RUN_G (after R done) → IDLE, `flags`=100, no `done`. Without it: same stimulus → full sequence completes.

Source files
------------

// File: rtl/rgb_dosing_sequencer.sv
// R->G->B dye motor sequencer: latches counts on start, runs each channel for N ticks.
// Optional `SEQ_ABORT_EN: an enter edge while running aborts back to IDLE.
module rgb_dosing_sequencer #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             enter,
    input  logic             rgb_full,
    input  logic [CNT_W-1:0] ciclos_r,
    input  logic [CNT_W-1:0] ciclos_g,
    input  logic [CNT_W-1:0] ciclos_b,
    output logic [2:0]       motores,
    output logic [2:0]       flags,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN_R,
        S_RUN_G,
        S_RUN_B,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    state_t           w_first;
    state_t           w_after_r;
    state_t           w_after_g;
    logic             r_enter_d;
    logic [CNT_W-1:0] r_cr;
    logic [CNT_W-1:0] r_cg;
    logic [CNT_W-1:0] r_cb;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cur;
    logic [2:0]       r_flags;
    logic [2:0]       r_motores;
    logic             r_busy;
    logic             r_done;
    logic [2:0]       w_motores;
    logic             w_busy;
    logic             w_done;
    logic             w_rise;
    logic             w_run;
    logic             w_start;
    logic             w_abort;
    logic             w_last;

    assign w_rise  = enter & ~r_enter_d;
    assign w_run   = (r_state == S_RUN_R) || (r_state == S_RUN_G) ||
                     (r_state == S_RUN_B);
    assign w_start = (r_state == S_IDLE) & w_rise & rgb_full;

`ifdef SEQ_ABORT_EN
    assign w_abort = w_run & w_rise;
`else
    assign w_abort = 1'b0;
`endif

    always_comb begin
        w_cur = '0;
        unique case (r_state)
            S_RUN_R: w_cur = r_cr;
            S_RUN_G: w_cur = r_cg;
            S_RUN_B: w_cur = r_cb;
            default: w_cur = '0;
        endcase
    end

    assign w_last = w_run & tick & (r_cnt == w_cur - CNT_W'(1));

    // Start uses the live inputs: they are being latched on this same edge
    assign w_first   = (ciclos_r != '0) ? S_RUN_R :
                       (ciclos_g != '0) ? S_RUN_G :
                       (ciclos_b != '0) ? S_RUN_B : S_DONE;
    assign w_after_r = (r_cg != '0) ? S_RUN_G :
                       (r_cb != '0) ? S_RUN_B : S_DONE;
    assign w_after_g = (r_cb != '0) ? S_RUN_B : S_DONE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_start) w_next = w_first;
            S_RUN_R: if (w_abort) w_next = S_IDLE;
                     else if (w_last) w_next = w_after_r;
            S_RUN_G: if (w_abort) w_next = S_IDLE;
                     else if (w_last) w_next = w_after_g;
            S_RUN_B: if (w_abort) w_next = S_IDLE;
                     else if (w_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered
    always_comb begin
        w_motores = {w_next == S_RUN_R, w_next == S_RUN_G, w_next == S_RUN_B};
        w_busy    = |w_motores;
        w_done    = (w_next == S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_motores <= 3'b000;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_motores <= w_motores;
            r_busy    <= w_busy;
            r_done    <= w_done;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_enter_d <= 1'b0;
            r_cr      <= '0;
            r_cg      <= '0;
            r_cb      <= '0;
            r_cnt     <= '0;
            r_flags   <= 3'b000;
        end else begin
            r_enter_d <= enter;
            if (w_start) begin
                r_cr    <= ciclos_r;
                r_cg    <= ciclos_g;
                r_cb    <= ciclos_b;
                r_cnt   <= '0;
                r_flags <= {ciclos_r == '0, ciclos_g == '0, ciclos_b == '0};
            end else if (w_abort || w_last) begin
                r_cnt <= '0;
                if (!w_abort) begin
                    unique case (r_state)
                        S_RUN_R: r_flags[2] <= 1'b1;
                        S_RUN_G: r_flags[1] <= 1'b1;
                        default: r_flags[0] <= 1'b1;
                    endcase
                end
            end else if (w_run && tick) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign motores = r_motores;
    assign busy    = r_busy;
    assign done    = r_done;
    assign flags   = r_flags;

endmodule

// File: tb/tb_rgb_dosing_sequencer.sv
// Directed bench for rgb_dosing_sequencer; honours `SEQ_ABORT_EN in the abort test.
module tb_rgb_dosing_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       enter = 1'b0;
    logic       rgb_full = 1'b0;
    logic [4:0] ciclos_r = '0;
    logic [4:0] ciclos_g = '0;
    logic [4:0] ciclos_b = '0;
    logic [2:0] motores;
    logic [2:0] flags;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_errors = 0;
    int n_done   = 0;
    int done_ref;

    rgb_dosing_sequencer #(.CNT_W(5)) dut (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .enter    (enter),
        .rgb_full (rgb_full),
        .ciclos_r (ciclos_r),
        .ciclos_g (ciclos_g),
        .ciclos_b (ciclos_b),
        .motores  (motores),
        .flags    (flags),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        check("onehot0", 32'($onehot0(motores)), 32'd1);
        if (done) n_done++;
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic press();
        enter = 1'b1;
        step();
        enter = 1'b0;
    endtask

    task automatic load(input logic [4:0] r, input logic [4:0] g,
                        input logic [4:0] b);
        ciclos_r = r;
        ciclos_g = g;
        ciclos_b = b;
    endtask

    task automatic expect_out(input string tag, input logic [2:0] m,
                              input logic [2:0] f, input logic b,
                              input logic d);
        check({tag, ".mot"},  32'(motores), 32'(m));
        check({tag, ".flg"},  32'(flags),   32'(f));
        check({tag, ".busy"}, 32'(busy),    32'(b));
        check({tag, ".done"}, 32'(done),    32'(d));
    endtask

    initial begin
        step();
        expect_out("rst", 3'b000, 3'b000, 1'b0, 1'b0);
        reset = 1'b0;
        step();
        pulse_tick();
        pulse_tick();
        expect_out("idle_tick", 3'b000, 3'b000, 1'b0, 1'b0);

        // 3/2/1 sequence
        load(5'd3, 5'd2, 5'd1);
        rgb_full = 1'b1;
        done_ref = n_done;
        press();
        expect_out("s1.start", 3'b100, 3'b000, 1'b1, 1'b0);
        pulse_tick();
        pulse_tick();
        expect_out("s1.r2", 3'b100, 3'b000, 1'b1, 1'b0);
        pulse_tick();
        expect_out("s1.g0", 3'b010, 3'b100, 1'b1, 1'b0);
        pulse_tick();
        expect_out("s1.g1", 3'b010, 3'b100, 1'b1, 1'b0);
        pulse_tick();
        expect_out("s1.b0", 3'b001, 3'b110, 1'b1, 1'b0);
        pulse_tick();
        expect_out("s1.end", 3'b000, 3'b111, 1'b0, 1'b1);
        step();
        expect_out("s1.idle", 3'b000, 3'b111, 1'b0, 1'b0);
        check("s1.ndone", 32'(n_done - done_ref), 32'd1);

        // only G
        load(5'd0, 5'd4, 5'd0);
        press();
        expect_out("s2.start", 3'b010, 3'b101, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) pulse_tick();
        expect_out("s2.g3", 3'b010, 3'b101, 1'b1, 1'b0);
        pulse_tick();
        expect_out("s2.end", 3'b000, 3'b111, 1'b0, 1'b1);
        step();

        // all zero
        load(5'd0, 5'd0, 5'd0);
        press();
        expect_out("s3.done", 3'b000, 3'b111, 1'b0, 1'b1);
        step();
        expect_out("s3.idle", 3'b000, 3'b111, 1'b0, 1'b0);

        // edge without rgb_full does not arm a later start
        load(5'd1, 5'd1, 5'd1);
        rgb_full = 1'b0;
        enter = 1'b1;
        step();
        rgb_full = 1'b1;
        step();
        step();
        expect_out("s4.held", 3'b000, 3'b111, 1'b0, 1'b0);
        enter = 1'b0;
        step();
        press();
        expect_out("s4.start", 3'b100, 3'b000, 1'b1, 1'b0);
        pulse_tick();
        pulse_tick();
        pulse_tick();
        expect_out("s4.end", 3'b000, 3'b111, 1'b0, 1'b1);
        step();

        // inputs after latch are ignored; async reset mid-G
        load(5'd2, 5'd3, 5'd1);
        press();
        pulse_tick();
        ciclos_r = 5'd9;
        pulse_tick();
        expect_out("s5.g0", 3'b010, 3'b100, 1'b1, 1'b0);
        pulse_tick();
        #2 reset = 1'b1;
        #1 expect_out("s5.arst", 3'b000, 3'b000, 1'b0, 1'b0);
        step();
        reset = 1'b0;
        step();
        expect_out("s5.post", 3'b000, 3'b000, 1'b0, 1'b0);

        // enter during RUN_G
        load(5'd1, 5'd3, 5'd1);
        done_ref = n_done;
        press();
        pulse_tick();
        expect_out("s6.g0", 3'b010, 3'b100, 1'b1, 1'b0);
        pulse_tick();
        press();
`ifdef SEQ_ABORT_EN
        expect_out("s6.abort", 3'b000, 3'b100, 1'b0, 1'b0);
        pulse_tick();
        step();
        expect_out("s6.idle", 3'b000, 3'b100, 1'b0, 1'b0);
        check("s6.ndone", 32'(n_done - done_ref), 32'd0);
`else
        expect_out("s6.ign", 3'b010, 3'b100, 1'b1, 1'b0);
        pulse_tick();
        pulse_tick();
        expect_out("s6.b0", 3'b001, 3'b110, 1'b1, 1'b0);
        pulse_tick();
        expect_out("s6.end", 3'b000, 3'b111, 1'b0, 1'b1);
        step();
        check("s6.ndone", 32'(n_done - done_ref), 32'd1);
`endif

        // max count runs the full 31 ticks
        load(5'd31, 5'd0, 5'd0);
        step();
        press();
        expect_out("s7.start", 3'b100, 3'b011, 1'b1, 1'b0);
        for (int i = 0; i < 30; i++) pulse_tick();
        expect_out("s7.t30", 3'b100, 3'b011, 1'b1, 1'b0);
        pulse_tick();
        expect_out("s7.end", 3'b000, 3'b111, 1'b0, 1'b1);
        step();

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
